// File: rtl/bit_deser.sv
// -----------------------------------------------------------------------------
// bit_deser: serial-to-parallel framer.
//
// This block consumes the 1-bit stream from the upstream dff stage. It scans
// that stream for the SYNC word. When it finds the word, it assembles
// FRAME_WORDS data words of WIDTH bits each, MSB first. Each finished word goes
// into a 2-entry FIFO that the consumer drains through a valid/ready handshake.
//
// Ports
//   clk         clock; all state updates on the rising edge
//   rst         asynchronous active-low reset, clears all state
//   din         serial data bit
//   din_en      qualifies din; a bit is sampled only when din_en=1
//   dout        head word of the output buffer
//   dout_valid  buffer holds at least one word
//   dout_ready  consumer takes the head on a cycle with dout_valid & dout_ready
//   locked      1 while collecting a frame
//   overflow    sticky; set when a completed word is dropped on a full buffer
//   state_dbg   framer state (0 = HUNT, 1 = COLLECT) for checkers
//
// Handshake: a word transfers on every rising edge where dout_valid and
// dout_ready are both 1. dout_valid does not depend on dout_ready. dout holds
// steady while dout_valid=1 and no transfer happens.
// -----------------------------------------------------------------------------
module bit_deser #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] SYNC        = 8'hA5,
  parameter int               FRAME_WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             locked,
  output logic             overflow,
  output logic             state_dbg
);

  localparam int BW  = $clog2(WIDTH);
  localparam int WCW = $clog2(FRAME_WORDS + 1);
  localparam logic [BW-1:0]  LAST_BIT  = BW'(WIDTH - 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(FRAME_WORDS - 1);

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] hunt_sh;
  logic [WIDTH-1:0] word_sh;
  logic [BW-1:0]    bit_cnt;
  logic [WCW-1:0]   word_cnt;

  logic [WIDTH-1:0] hunt_nxt;
  logic [WIDTH-1:0] word_done;
  logic             sync_hit;
  logic             word_push;
  logic             frame_end;

  // The hunt compares against the value after the shift. Because of that,
  // the sync word is recognised on the edge that samples its last bit.
  assign hunt_nxt  = {hunt_sh[WIDTH-2:0], din};
  assign word_done = {word_sh[WIDTH-2:0], din};
  assign sync_hit  = (state == HUNT) && din_en && (hunt_nxt == SYNC);
  assign word_push = (state == COLLECT) && din_en && (bit_cnt == LAST_BIT);
  assign frame_end = word_push && (word_cnt == LAST_WORD);

  // ---------------------------------------------------------------------------
  // Framer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:    if (sync_hit)  state_nxt = COLLECT;
      COLLECT: if (frame_end) state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shift registers and counters. When din_en=0, every one of them holds.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hunt_sh  <= '0;
      word_sh  <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
    end else if (din_en) begin
      if (state == HUNT) begin
        if (sync_hit) begin
          // Start the next hunt from a clean window. This keeps bits from
          // before the frame out of the next sync match.
          hunt_sh  <= '0;
          bit_cnt  <= '0;
          word_cnt <= '0;
        end else begin
          hunt_sh <= hunt_nxt;
        end
      end else begin
        word_sh <= word_done;
        if (word_push) begin
          bit_cnt  <= '0;
          word_cnt <= frame_end ? '0 : word_cnt + WCW'(1);
        end else begin
          bit_cnt <= bit_cnt + BW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // 2-entry output FIFO
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             full;
  logic             pop;
  logic             accept;
  logic             drop;

  assign full   = (count == 2'd2);
  assign pop    = dout_valid && dout_ready;
  // A pop in the same cycle frees a slot, so a push on a full buffer
  // is accepted when a pop happens alongside it.
  assign accept = word_push && (!full || pop);
  assign drop   = word_push && full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= word_done;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign dout       = mem[rd_ptr];
  assign dout_valid = (count != 2'd0);
  assign locked     = (state == COLLECT);
  assign state_dbg  = state;

endmodule

// File: tb/tb_bit_deser.sv
// -----------------------------------------------------------------------------
// tb_bit_deser: self-checking bench for bit_deser.
//
// The bench expresses each scenario as a list of qualified bits. A reference
// model walks that list using the framing rules and marks where sync locks and
// where each data word ends. The driver feeds the bits, inserting optional
// din_en gaps. It also keeps a word-level model of buffer occupancy. From that
// model it decides whether each completed word is accepted, which pushes the
// word into exp_q, or dropped, which sets the expected overflow. A separate
// monitor pops exp_q on every observed handshake transfer and compares the
// popped word with dout.
// -----------------------------------------------------------------------------
module tb_bit_deser;

  localparam int W  = 8;
  localparam int FW = 4;
  localparam logic [W-1:0] SYNC = 8'hA5;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         din;
  logic         din_en;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         locked;
  logic         overflow;
  logic         state_dbg;

  bit_deser #(.WIDTH(W), .SYNC(SYNC), .FRAME_WORDS(FW)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_en    (din_en),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .locked    (locked),
    .overflow  (overflow),
    .state_dbg (state_dbg)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int           occ;
  logic         exp_locked;
  logic         exp_ovf;
  int           n_checks = 0;
  int           n_pass   = 0;

  // scenario description and reference-model annotations
  logic         q_bits[$];
  logic         is_end[$];
  logic [W-1:0] word_val[$];
  logic         lock_after[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_byte(input logic [W-1:0] v);
    for (int i = W - 1; i >= 0; i--) q_bits.push_back(v[i]);
  endtask

  task automatic push_bit(input logic b);
    q_bits.push_back(b);
  endtask

  // Reference framer model over the qualified bit list. The hunt window holds
  // only the bits seen since the last hunt started. Any missing older
  // positions read as zero.
  task automatic build_model();
    int           hunt_start;
    bit           collecting;
    int           nbits;
    int           nwords;
    logic [W-1:0] cur;
    logic [W-1:0] win;
    int           lo;
    is_end.delete(); word_val.delete(); lock_after.delete();
    hunt_start = 0; collecting = 0; nbits = 0; nwords = 0; cur = '0;
    for (int k = 0; k < q_bits.size(); k++) begin
      is_end.push_back(1'b0);
      word_val.push_back('0);
      if (!collecting) begin
        win = '0;
        lo  = (k - W + 1 > hunt_start) ? k - W + 1 : hunt_start;
        for (int j = lo; j <= k; j++) win = {win[W-2:0], q_bits[j]};
        if (win == SYNC) begin
          collecting = 1; nbits = 0; nwords = 0;
        end
      end else begin
        cur = {cur[W-2:0], q_bits[k]};
        nbits++;
        if (nbits == W) begin
          is_end[k]   = 1'b1;
          word_val[k] = cur;
          nbits = 0;
          nwords++;
          if (nwords == FW) begin
            collecting = 0;
            hunt_start = k + 1;
          end
        end
      end
      lock_after.push_back(collecting);
    end
  endtask

  // One clock cycle. The task is entered at posedge+1, drives the inputs,
  // applies the model update at the edge, then checks at posedge+1.
  task automatic do_cycle(input logic b, input logic en, input logic rdy,
                          input logic end_bit, input logic [W-1:0] w, input logic lk);
    bit pop_now;
    bit push_now;
    din = b; din_en = en; dout_ready = rdy;
    pop_now  = (occ > 0) && rdy;
    push_now = en && end_bit;
    @(posedge clk);
    if (pop_now) occ--;
    if (push_now) begin
      if (occ == 2) exp_ovf = 1'b1;
      else begin
        exp_q.push_back(w);
        occ++;
      end
    end
    if (en) exp_locked = lk;
    #1;
    check("locked", locked, exp_locked);
    check("state_dbg", state_dbg, exp_locked);
    check("overflow", overflow, exp_ovf);
    check("dout_valid", dout_valid, occ > 0);
  endtask

  // en_mode: 0 continuous, 1 alternate 1/0, 2 random gaps.
  // The bench holds ready at 1 from qualified bit ready_from onward,
  // unless rdy_rand is set.
  task automatic drive_stream(input int en_mode, input int ready_from,
                              input bit rdy_rand, input int drain);
    logic rdy;
    build_model();
    for (int k = 0; k < q_bits.size(); k++) begin
      rdy = rdy_rand ? logic'($urandom_range(0, 1)) : (k >= ready_from);
      if (en_mode == 2) begin
        for (int g = $urandom_range(0, 2); g > 0; g--)
          do_cycle(logic'($urandom_range(0, 1)), 1'b0, rdy, 1'b0, '0, 1'b0);
      end
      do_cycle(q_bits[k], 1'b1, rdy, is_end[k], word_val[k], lock_after[k]);
      if (en_mode == 1)
        do_cycle(logic'($urandom_range(0, 1)), 1'b0, rdy, 1'b0, '0, 1'b0);
    end
    for (int i = 0; i < drain; i++)
      do_cycle(logic'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0, '0, 1'b0);
    if (drain > 0) check("exp_q_empty", exp_q.size(), 0);
    q_bits.delete();
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #1;
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_overflow", overflow, 0);
    exp_q.delete(); occ = 0; exp_locked = 1'b0; exp_ovf = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // monitor: a transfer happens at the next edge whenever valid & ready
  always @(negedge clk) begin
    if (rst && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) check("unexpected_word", dout, 32'hFFFF_FFFF);
      else check("dout_word", dout, exp_q.pop_front());
    end
  end

  initial begin
    rst = 1'b0; din = 1'b0; din_en = 1'b0; dout_ready = 1'b0;
    occ = 0; exp_locked = 1'b0; exp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    apply_reset();

    // basic frame
    push_byte(SYNC); push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_byte(8'h04);
    drive_stream(0, 0, 0, 6);
    apply_reset();

    // sync hunting: noise, overlapping partial prefix, sync, data including SYNC
    push_bit(1); push_bit(0); push_bit(1); push_bit(1); push_bit(0);
    push_bit(1); push_bit(0); push_bit(1); push_bit(0);
    push_byte(SYNC); push_byte(SYNC); push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    drive_stream(0, 0, 0, 6);
    apply_reset();

    // backpressure for the whole frame
    push_byte(SYNC); push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_byte(8'h04);
    drive_stream(0, 1000, 0, 6);
    apply_reset();

    // simultaneous push/pop: ready rises on the last bit of word 03
    push_byte(SYNC); push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_byte(8'h04);
    drive_stream(0, 4 * W - 1, 0, 6);
    apply_reset();

    // gapped input
    push_byte(SYNC); push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_byte(8'h04);
    drive_stream(1, 0, 0, 6);
    apply_reset();

    // reset in the middle of word 02, then continue without a new sync
    push_byte(SYNC); push_byte(8'h01);
    push_bit(0); push_bit(0); push_bit(0); push_bit(0);
    drive_stream(0, 0, 0, 0);
    apply_reset();
    push_bit(0); push_bit(0); push_bit(1); push_bit(0);
    push_byte(8'h03); push_byte(8'h04); push_byte(8'h5A);
    drive_stream(0, 0, 0, 6);
    apply_reset();

    // randomized frames with noise, random gaps and random backpressure
    for (int s = 0; s < 12; s++) begin
      for (int n = $urandom_range(0, 12); n > 0; n--) push_bit(logic'($urandom_range(0, 1)));
      push_byte(SYNC);
      for (int i = 0; i < FW; i++) push_byte(W'($urandom_range(0, 255)));
    end
    drive_stream(2, 0, 1, 8);
    apply_reset();

    // random stream with steady ready and random gaps
    for (int s = 0; s < 8; s++) begin
      for (int n = $urandom_range(0, 6); n > 0; n--) push_bit(logic'($urandom_range(0, 1)));
      push_byte(SYNC);
      for (int i = 0; i < FW; i++) push_byte(W'($urandom_range(0, 255)));
    end
    drive_stream(2, 0, 0, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
